// File: rtl/uart_rx_fifo_if.sv
// CPU-facing bundle of the UART receiver: serial line in, pop/flush strobes, FIFO head and status out.
interface uart_rx_fifo_if;
  logic       RX_IN;
  logic       READ_IN;
  logic       CLEAR_IN;
  logic [7:0] DATA_OUT;
  logic       DATA_PRESENT_OUT;
  logic       HALF_FULL_OUT;
  logic       FULL_OUT;
  logic       FRAMING_ERROR_OUT;
  logic       OVERRUN_OUT;

  modport master (
    output RX_IN, READ_IN, CLEAR_IN,
    input  DATA_OUT, DATA_PRESENT_OUT, HALF_FULL_OUT, FULL_OUT,
           FRAMING_ERROR_OUT, OVERRUN_OUT
  );

  modport slave (
    input  RX_IN, READ_IN, CLEAR_IN,
    output DATA_OUT, DATA_PRESENT_OUT, HALF_FULL_OUT, FULL_OUT,
           FRAMING_ERROR_OUT, OVERRUN_OUT
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling) feeding a first-word fall-through byte FIFO.
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | qualifying the start bit at its midpoint
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_fifo #(
  parameter int CLKS_PER_TICK = 54,
  parameter int FIFO_AW       = 4
) (
  input logic          CLK_IN,
  input logic          RESET_N_IN,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TW-1:0]    TICK_TC = TW'(CLKS_PER_TICK - 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] HALF_C  = (FIFO_AW + 1)'(DEPTH / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  logic [TW-1:0] div_q;
  logic          tick;
  logic          rx_meta_q, rx_sync_q;
  state_t        state_q, state_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_set;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ferr_q, ovr_q;
  logic               full, pop, wr_en;

  assign tick = (div_q == TICK_TC);

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      div_q     <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      div_q     <= tick ? '0 : div_q + 1'b1;
      rx_meta_q <= bus.RX_IN;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q <= S_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          os_d    = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            if (!rx_sync_q) begin
              os_d    = '0;
              bit_d   = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            push_d   = rx_sync_q;
            ferr_set = !rx_sync_q;
            state_d  = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign full  = (cnt_q == DEPTH_C);
  assign pop   = bus.READ_IN && (cnt_q != '0);
  assign wr_en = push_q && (!full || pop) && !bus.CLEAR_IN;

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (bus.CLEAR_IN) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
      if (ferr_set) ferr_q <= 1'b1;
      if (push_q && full && !pop) ovr_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_q] <= shift_q;
    end
  end

  assign bus.DATA_OUT          = mem_q[rd_q];
  assign bus.DATA_PRESENT_OUT  = (cnt_q != '0);
  assign bus.HALF_FULL_OUT     = (cnt_q >= HALF_C);
  assign bus.FULL_OUT          = full;
  assign bus.FRAMING_ERROR_OUT = ferr_q;
  assign bus.OVERRUN_OUT       = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: byte-queue model compared every settled cycle, plus literal checks.
module tb_uart_rx_fifo;
  localparam int CPT   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BIT   = 16 * CPT;
  localparam int FRAME = 10 * BIT;

  logic CLK_IN     = 1'b0;
  logic RESET_N_IN = 1'b0;
  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CLKS_PER_TICK(CPT), .FIFO_AW(AW)) dut (
    .CLK_IN    (CLK_IN),
    .RESET_N_IN(RESET_N_IN),
    .bus       (bus)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit settled = 1'b0;
  logic [7:0] q[$];
  bit m_ferr = 1'b0;
  bit m_ovr  = 1'b0;
  logic [7:0] d;
  int c0, c1, lat;

  always @(posedge CLK_IN) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO contents as a byte queue plus the two sticky flags.
  always @(negedge CLK_IN) begin
    if (settled && RESET_N_IN) begin
      chk("model_present", 32'(bus.DATA_PRESENT_OUT), 32'(q.size() != 0));
      if (q.size() != 0) chk("model_data", 32'(bus.DATA_OUT), 32'(q[0]));
      chk("model_half", 32'(bus.HALF_FULL_OUT), 32'(q.size() >= DEPTH / 2));
      chk("model_full", 32'(bus.FULL_OUT), 32'(q.size() == DEPTH));
      chk("model_ferr", 32'(bus.FRAMING_ERROR_OUT), 32'(m_ferr));
      chk("model_ovr", 32'(bus.OVERRUN_OUT), 32'(m_ovr));
    end
  end

  task automatic m_push(input logic [7:0] b);
    if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK_IN);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    bus.RX_IN = v;
    idle(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    line(stop, BIT);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    settled = 1'b0;
    send_frame(b, 1'b1);
    m_push(b);
    settled = 1'b1;
  endtask

  task automatic cpu_read(output logic [7:0] v);
    v = bus.DATA_OUT;
    bus.READ_IN = 1'b1;
    idle(1);
    bus.READ_IN = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic cpu_clear();
    bus.CLEAR_IN = 1'b1;
    idle(1);
    bus.CLEAR_IN = 1'b0;
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic align();
    do begin
      @(posedge CLK_IN);
      #1;
    end while (cyc % CPT != 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},    32'(bus.DATA_OUT), 32'h00);
    chk({tag, "_present"}, 32'(bus.DATA_PRESENT_OUT), 32'd0);
    chk({tag, "_half"},    32'(bus.HALF_FULL_OUT), 32'd0);
    chk({tag, "_full"},    32'(bus.FULL_OUT), 32'd0);
    chk({tag, "_ferr"},    32'(bus.FRAMING_ERROR_OUT), 32'd0);
    chk({tag, "_ovr"},     32'(bus.OVERRUN_OUT), 32'd0);
  endtask

  initial begin
    logic [7:0] t2_exp [3];
    t2_exp = '{8'h00, 8'hFF, 8'hA5};
    bus.RX_IN    = 1'b1;
    bus.READ_IN  = 1'b0;
    bus.CLEAR_IN = 1'b0;
    idle(3);
    chk_reset_vals("reset");
    RESET_N_IN = 1'b1;
    idle(2 * BIT);
    settled = 1'b1;

    // single byte
    rx_byte(8'h55);
    idle(4);
    chk("t1_present", 32'(bus.DATA_PRESENT_OUT), 32'd1);
    chk("t1_data", 32'(bus.DATA_OUT), 32'h55);
    chk("t1_ferr", 32'(bus.FRAMING_ERROR_OUT), 32'd0);
    cpu_read(d);
    chk("t1_read", 32'(d), 32'h55);
    chk("t1_empty", 32'(bus.DATA_PRESENT_OUT), 32'd0);

    // back-to-back frames
    settled = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(t2_exp[i], 1'b1);
    for (int i = 0; i < 3; i++) m_push(t2_exp[i]);
    settled = 1'b1;
    idle(4);
    chk("t2_half", 32'(bus.HALF_FULL_OUT), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cpu_read(d);
      chk("t2_read", 32'(d), 32'(t2_exp[i]));
    end
    chk("t2_empty", 32'(bus.DATA_PRESENT_OUT), 32'd0);

    // 200 ns glitch: no byte must appear
    line(1'b0, 20);
    line(1'b1, 2 * BIT);
    chk("t3_present", 32'(bus.DATA_PRESENT_OUT), 32'd0);
    chk("t3_ferr", 32'(bus.FRAMING_ERROR_OUT), 32'd0);

    // framing error with break, then a good byte
    settled = 1'b0;
    send_frame(8'h3C, 1'b0);
    line(1'b0, 2 * BIT);
    line(1'b1, BIT);
    m_ferr = 1'b1;
    send_frame(8'h81, 1'b1);
    m_push(8'h81);
    settled = 1'b1;
    idle(4);
    chk("t4_ferr", 32'(bus.FRAMING_ERROR_OUT), 32'd1);
    chk("t4_data", 32'(bus.DATA_OUT), 32'h81);
    cpu_read(d);
    chk("t4_read", 32'(d), 32'h81);
    chk("t4_empty", 32'(bus.DATA_PRESENT_OUT), 32'd0);
    cpu_clear();
    chk("t4_ferr_clr", 32'(bus.FRAMING_ERROR_OUT), 32'd0);

    // fill to overflow
    for (int i = 0; i < 17; i++) begin
      rx_byte(8'(i));
      if (i == 6)  chk("t5_half_at7", 32'(bus.HALF_FULL_OUT), 32'd0);
      if (i == 7)  chk("t5_half_at8", 32'(bus.HALF_FULL_OUT), 32'd1);
      if (i == 14) chk("t5_full_at15", 32'(bus.FULL_OUT), 32'd0);
      if (i == 15) begin
        chk("t5_full_at16", 32'(bus.FULL_OUT), 32'd1);
        chk("t5_ovr_at16", 32'(bus.OVERRUN_OUT), 32'd0);
      end
      if (i == 16) chk("t5_ovr_at17", 32'(bus.OVERRUN_OUT), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      cpu_read(d);
      chk("t5_read", 32'(d), 32'(i));
    end
    chk("t5_empty", 32'(bus.DATA_PRESENT_OUT), 32'd0);
    chk("t5_ovr_sticky", 32'(bus.OVERRUN_OUT), 32'd1);
    cpu_clear();

    // full FIFO, pop on the push cycle: locate the push cycle from the 16th byte
    for (int i = 0; i < 15; i++) rx_byte(8'h20 + 8'(i));
    settled = 1'b0;
    align();
    c0 = cyc;
    c1 = -1;
    fork
      send_frame(8'h2F, 1'b1);
      begin
        for (int k = 0; k < 2 * FRAME; k++) begin
          @(negedge CLK_IN);
          if (bus.FULL_OUT) begin
            c1 = cyc;
            break;
          end
        end
      end
    join
    m_push(8'h2F);
    settled = 1'b1;
    chk("t6_full_seen", 32'(c1 >= 0), 32'd1);
    lat = (c1 >= 0) ? (c1 - c0) : (FRAME - BIT);
    settled = 1'b0;
    align();
    c0 = cyc;
    fork
      send_frame(8'h30, 1'b1);
      begin
        while (cyc < c0 + lat - 1) begin
          @(posedge CLK_IN);
          #1;
        end
        bus.READ_IN = 1'b1;
        idle(1);
        bus.READ_IN = 1'b0;
      end
    join
    void'(q.pop_front());
    m_push(8'h30);
    settled = 1'b1;
    idle(2);
    chk("t6_ovr", 32'(bus.OVERRUN_OUT), 32'd0);
    chk("t6_full", 32'(bus.FULL_OUT), 32'd1);
    chk("t6_head", 32'(bus.DATA_OUT), 32'h21);
    cpu_clear();
    chk("t6_clr_present", 32'(bus.DATA_PRESENT_OUT), 32'd0);
    chk("t6_clr_full", 32'(bus.FULL_OUT), 32'd0);
    chk("t6_clr_half", 32'(bus.HALF_FULL_OUT), 32'd0);
    chk("t6_clr_ovr", 32'(bus.OVERRUN_OUT), 32'd0);

    // reset mid-frame
    rx_byte(8'h99);
    idle(2);
    chk("t7_pre_present", 32'(bus.DATA_PRESENT_OUT), 32'd1);
    settled = 1'b0;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(3 * BIT);
        RESET_N_IN = 1'b0;
        idle(2);
        chk_reset_vals("t7_rst");
        RESET_N_IN = 1'b1;
      end
    join
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    settled = 1'b1;
    idle(BIT);
    chk("t7_post_present", 32'(bus.DATA_PRESENT_OUT), 32'd0);
    rx_byte(8'h42);
    idle(2);
    chk("t7_data", 32'(bus.DATA_OUT), 32'h42);
    cpu_read(d);
    chk("t7_read", 32'(d), 32'h42);
    chk("t7_empty", 32'(bus.DATA_PRESENT_OUT), 32'd0);

    settled = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
